// File: rtl/peak_event_logger_if.sv
// Event record handshake between the peak event logger and its consumer.
// The logger drives the head record and its valid flag; the consumer
// answers with ready when it takes the record.
interface peak_event_logger_if #(
  parameter int TS_W = 8
);
  logic            evt_valid;
  logic            evt_ready;
  logic [1:0]      evt_level;
  logic [TS_W-1:0] evt_time;

  modport master (
    output evt_valid,
    output evt_level,
    output evt_time,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_level,
    input  evt_time,
    output evt_ready
  );
endinterface

// File: rtl/peak_event_logger.sv
// Peak event logger: watches the 2-bit "highest level seen" output of the
// upstream tracker, timestamps every change with a free-running cycle
// counter and queues the change records in a small circular FIFO that a
// consumer drains over a valid/ready handshake. Records that arrive while
// the FIFO is full (and nothing is popped) are dropped and flagged through
// a sticky overflow bit. The head record is held in dedicated output
// registers, so every output comes straight from a flop.
module peak_event_logger #(
  parameter int DEPTH = 4,
  parameter int TS_W  = 8
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       clr,
  input  logic [1:0]                 level_in,
  peak_event_logger_if.master        evt,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       overflow,
  output logic                       level_changed
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int REC_W = 2 + TS_W;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [TS_W-1:0]  ts_q, ts_d;
  logic [1:0]       prev_level_q, prev_level_d;
  logic [REC_W-1:0] mem_q [DEPTH];
  logic [REC_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             changed_q, changed_d;
  logic             valid_q, valid_d;
  logic [1:0]       head_level_q, head_level_d;
  logic [TS_W-1:0]  head_time_q, head_time_d;

  logic             change;
  logic             pop;
  logic             full;
  logic             do_push;

  // Next-state logic: change detection, FIFO push/pop, overflow and the
  // look-ahead of the head record so it lands in the output registers.
  always_comb begin
    ts_d         = ts_q + TS_W'(1);
    prev_level_d = level_in;
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    overflow_d   = overflow_q;
    changed_d    = 1'b0;
    head_level_d = head_level_q;
    head_time_d  = head_time_q;
    change       = (level_in != prev_level_q);
    pop          = valid_q && evt.evt_ready;
    full         = (count_q == FULL_CNT);
    do_push      = 1'b0;

    if (clr) begin
      ts_d         = '0;
      prev_level_d = 2'b00;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
      overflow_d   = 1'b0;
    end else begin
      changed_d = change;
      // A pop on a full FIFO frees the slot the new record goes into.
      do_push   = change && (!full || pop);
      if (change && full && !pop) begin
        overflow_d = 1'b1;
      end
      if (do_push) begin
        mem_d[wr_ptr_q] = {level_in, ts_q};
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end

    valid_d = (count_d != '0);
    // When the FIFO goes empty the head registers simply keep their old value.
    if (valid_d) begin
      {head_level_d, head_time_d} = mem_d[rd_ptr_d];
    end
  end

  // State register with asynchronous active-low reset; reset drops all records.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ts_q         <= '0;
      prev_level_q <= 2'b00;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      changed_q    <= 1'b0;
      valid_q      <= 1'b0;
      head_level_q <= 2'b00;
      head_time_q  <= '0;
    end else begin
      ts_q         <= ts_d;
      prev_level_q <= prev_level_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      changed_q    <= changed_d;
      valid_q      <= valid_d;
      head_level_q <= head_level_d;
      head_time_q  <= head_time_d;
    end
  end

  assign evt.evt_valid = valid_q;
  assign evt.evt_level = head_level_q;
  assign evt.evt_time  = head_time_q;
  assign fifo_count    = count_q;
  assign overflow      = overflow_q;
  assign level_changed = changed_q;

endmodule

// File: doc/peak_event_logger.md
Name: peak_event_logger

Overview:
- Sits directly downstream of the highest-value tracker FSM and consumes its 2-bit "highest level seen" output.
- Detects every change of that level and timestamps it with a free-running cycle counter.
- Queues each change as an event record in a small FIFO.
- Hands records to a consumer over a valid/ready interface, with sticky overflow reporting when records are lost.

Parameters:
- DEPTH, 4, FIFO depth in records; power of two, minimum 2.
- TS_W, 8, timestamp counter width in bits.

Ports:
- clk  input  1  clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- clr  input  1  synchronous clear; flushes FIFO, zeroes timestamp, clears overflow, re-arms detector.
- level_in  input  2  current highest level from the upstream tracker FSM.
- evt_valid  output  1  head record available.
- evt_ready  input  1  consumer accepts head record.
- evt_level  output  2  level value of head record.
- evt_time  output  TS_W  timestamp of head record.
- fifo_count  output  $clog2(DEPTH)+1  number of stored records.
- overflow  output  1  sticky; set when an event is dropped.
- level_changed  output  1  one-cycle registered pulse, one cycle after a change is detected.

Behaviour:
- Reset (rstn low, asynchronous): clears ts counter, prev_level, FIFO pointers and count, overflow, and level_changed.
  - Resulting outputs: evt_valid=0, evt_level=0, evt_time=0, fifo_count=0, overflow=0, level_changed=0.
  - Reset mid-operation discards all queued records with no further handshake.
- Timestamp counter ts:
  - Equals 0 at the first rising edge after rstn deasserts.
  - Increments by 1 every edge and wraps from 2^TS_W-1 to 0.
  - Does not saturate.
- Change detection:
  - Each edge compares level_in against prev_level; prev_level <= level_in.
  - A change is any inequality, including decreases, since the upstream tracker can be reset independently.
  - On change, push record {level_in, ts}, where ts is the counter value before this edge's increment. level_changed=1 the next cycle.
- FIFO:
  - Circular buffer, read/write pointers wrap modulo DEPTH.
  - Record written at edge N is visible at the outputs after edge N (evt_valid=1 in cycle N+1). There is no same-cycle bypass.
  - Pop occurs when evt_valid && evt_ready at an edge.
  - While evt_valid=1 and evt_ready=0, evt_level and evt_time are held stable.
  - When empty, evt_valid=0; evt_level and evt_time hold their last values (don't-care).
- Simultaneous push and pop:
  - Not full: both occur; fifo_count is unchanged.
  - Full: the pop frees a slot and the push is accepted; no overflow.
- Full with push and no pop:
  - New record is dropped; overflow <= 1 and stays set until clr or reset.
  - Existing contents are untouched.
- Pop when empty: ignored; pointers are unchanged.
- clr=1 (priority over push/pop):
  - FIFO emptied; ts <= 0; overflow <= 0; prev_level <= 2'b00; level_changed <= 0.
  - No event is generated in the clr cycle.
  - If level_in is nonzero after clr, an event is logged on the next edge, with time 0.
- fifo_count is always in 0..DEPTH.
- All outputs are registered.

Test Plan:
- Basic capture:
  - Stimulus: release reset; level_in=0 for edges 0-4; level_in=1 from edge 5; evt_ready=1.
  - Response: evt_valid=1 for exactly one cycle after edge 5, with evt_level=1, evt_time=5; level_changed pulses once.
- Monotonic sequence:
  - Stimulus: level_in steps 0→1 at edge 2, →2 at edge 4, →3 at edge 7; evt_ready=0.
  - Response: fifo_count=3; then raising evt_ready drains, in order, (1,2), (2,4), (3,7).
- Overflow (DEPTH=4):
  - Stimulus: evt_ready=0; 5 changes alternating level_in 1,2,1,2,1 on consecutive edges 0-4.
  - Response: fifo_count=4, overflow=1; drained records are (1,0), (2,1), (1,2), (2,3).
- Full with simultaneous push and pop:
  - Stimulus: FIFO full; one edge with evt_ready=1 and a level change.
  - Response: fifo_count stays 4, overflow stays 0, and the new record is last out.
- Timestamp wrap (TS_W=8):
  - Stimulus: change level_in at edge 255 and again at edge 257.
  - Response: records carry times 255 and 1.
- Clear and reset mid-operation:
  - Stimulus: 2 records queued, overflow=1; pulse clr with level_in=3.
  - Response: fifo_count=0 and overflow=0 the next cycle, then a record (3,0).
  - Then assert rstn=0 with 1 record queued. Response: evt_valid=0 and fifo_count=0 immediately, without waiting for a clock edge.
